// File: rtl/mem_stage_pipe.sv
// MEM pipeline stage: registers the EX/MEM payload, issues sized byte-enabled data-memory
// requests, aligns/extends load data and registers the writeback result.
// Optional misalignment trapping is enabled with `define MEM_STAGE_MISALIGN_TRAP_EN.
module mem_stage_pipe #(
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_e,
   input  logic                  reg_write_e,
   input  logic                  mem_read_e,
   input  logic                  mem_write_e,
   input  logic [1:0]            size_e,
   input  logic                  unsigned_e,
   input  logic [DATA_W-1:0]     alu_out_e,
   input  logic [DATA_W-1:0]     write_data_e,
   input  logic [REG_ADDR_W-1:0] write_reg_e,
   output logic                  stall_m,
   output logic                  dmem_valid,
   output logic                  dmem_write,
   output logic [ADDR_W-1:0]     dmem_addr,
   output logic [DATA_W-1:0]     dmem_wdata,
   output logic [DATA_W/8-1:0]   dmem_be,
   input  logic [DATA_W-1:0]     dmem_rdata,
   input  logic [1:0]            dmem_status,
   output logic                  wb_valid_m,
   output logic                  wb_reg_write_m,
   output logic [REG_ADDR_W-1:0] wb_write_reg_m,
   output logic [DATA_W-1:0]     wb_data_m,
   output logic [1:0]            exc_m
);

   localparam int unsigned BeW  = DATA_W / 8;
   localparam int unsigned OffW = $clog2(BeW);

   typedef enum logic {StIdle, StAccess} state_e;

   state_e                state_q, state_d;
   logic                  m_valid_q, m_valid_d;
   logic                  m_reg_write_q, m_reg_write_d;
   logic                  m_read_q, m_read_d;
   logic                  m_write_q, m_write_d;
   logic [1:0]            m_size_q, m_size_d;
   logic                  m_unsigned_q, m_unsigned_d;
   logic [DATA_W-1:0]     m_alu_q, m_alu_d;
   logic [DATA_W-1:0]     m_wdata_q, m_wdata_d;
   logic [REG_ADDR_W-1:0] m_reg_q, m_reg_d;
   logic [1:0]            m_exc_q, m_exc_d;

   logic                  wb_valid_q, wb_valid_d;
   logic                  wb_reg_write_q, wb_reg_write_d;
   logic [REG_ADDR_W-1:0] wb_write_reg_q, wb_write_reg_d;
   logic [DATA_W-1:0]     wb_data_q, wb_data_d;
   logic [1:0]            exc_q, exc_d;

   logic                  mem_op_e;
   logic                  illegal_e;
   logic                  misal_e;
   logic [1:0]            exc_e;
   logic                  access;
   logic                  retire;
   logic [OffW-1:0]       off;
   logic [BeW-1:0]        be;
   logic [DATA_W-1:0]     wdata_rep;
   logic [ADDR_W-1:0]     addr_base;
   logic [DATA_W-1:0]     rd_shifted;
   logic [DATA_W-1:0]     load_data;
   logic                  ld_sign;
   int unsigned           ld_bits;

   // Exceptions detected at capture never reach the memory.
   assign mem_op_e  = mem_read_e | mem_write_e;
   assign illegal_e = mem_op_e && (DATA_W == 32) && (size_e == 2'b11);

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
   logic [OffW-1:0] off_e;
   assign off_e = alu_out_e[OffW-1:0];
   always_comb begin
      misal_e = 1'b0;
      case (size_e)
         2'b01:   misal_e = off_e[0];
         2'b10:   misal_e = |off_e[1:0];
         2'b11:   misal_e = |off_e;
         default: misal_e = 1'b0;
      endcase
      misal_e = misal_e & mem_op_e;
   end
`else
   assign misal_e = 1'b0;
`endif

   assign exc_e = illegal_e ? 2'b11 : (misal_e ? 2'b01 : 2'b00);

   assign access  = (state_q == StAccess);
   assign stall_m = access & ~dmem_status[1];
   assign retire  = m_valid_q & ~stall_m;

   always_comb begin
      state_d       = state_q;
      m_valid_d     = m_valid_q;
      m_reg_write_d = m_reg_write_q;
      m_read_d      = m_read_q;
      m_write_d     = m_write_q;
      m_size_d      = m_size_q;
      m_unsigned_d  = m_unsigned_q;
      m_alu_d       = m_alu_q;
      m_wdata_d     = m_wdata_q;
      m_reg_d       = m_reg_q;
      m_exc_d       = m_exc_q;
      if (!stall_m) begin
         m_valid_d     = valid_e;
         m_reg_write_d = reg_write_e;
         m_read_d      = mem_read_e;
         m_write_d     = mem_write_e;
         m_size_d      = size_e;
         m_unsigned_d  = unsigned_e;
         m_alu_d       = alu_out_e;
         m_wdata_d     = write_data_e;
         m_reg_d       = write_reg_e;
         m_exc_d       = exc_e;
         state_d       = (valid_e && mem_op_e && (exc_e == 2'b00)) ? StAccess : StIdle;
      end
   end

   // Low offset bits below the access size are dropped (aligned container).
   always_comb begin
      off = m_alu_q[OffW-1:0];
      case (m_size_q)
         2'b01:   off[0] = 1'b0;
         2'b10:   off[1:0] = 2'b00;
         2'b11:   off = '0;
         default: ;
      endcase
   end

   always_comb begin
      be        = '1;
      wdata_rep = m_wdata_q;
      case (m_size_q)
         2'b00: begin
            be        = BeW'(1) << off;
            wdata_rep = {BeW{m_wdata_q[7:0]}};
         end
         2'b01: begin
            be        = BeW'(3) << off;
            wdata_rep = {(BeW / 2){m_wdata_q[15:0]}};
         end
         2'b10: begin
            be        = BeW'(15) << off;
            wdata_rep = {(DATA_W / 32){m_wdata_q[31:0]}};
         end
         default: begin
            be        = '1;
            wdata_rep = m_wdata_q;
         end
      endcase
   end

   generate
      if (ADDR_W <= DATA_W) begin : g_addr_trunc
         assign addr_base = m_alu_q[ADDR_W-1:0];
      end else begin : g_addr_ext
         assign addr_base = {{(ADDR_W - DATA_W){1'b0}}, m_alu_q};
      end
   endgenerate

   assign dmem_valid = access;
   assign dmem_write = access & m_write_q;
   assign dmem_addr  = access ? {addr_base[ADDR_W-1:OffW], {OffW{1'b0}}} : '0;
   assign dmem_wdata = access ? wdata_rep : '0;
   assign dmem_be    = access ? be : '0;

   assign rd_shifted = dmem_rdata >> {off, 3'b000};

   always_comb begin
      case (m_size_q)
         2'b00:   begin ld_bits = 8;      ld_sign = rd_shifted[7];        end
         2'b01:   begin ld_bits = 16;     ld_sign = rd_shifted[15];       end
         2'b10:   begin ld_bits = 32;     ld_sign = rd_shifted[31];       end
         default: begin ld_bits = DATA_W; ld_sign = rd_shifted[DATA_W-1]; end
      endcase
      ld_sign = ld_sign & ~m_unsigned_q;
      load_data = rd_shifted;
      for (int i = 0; i < DATA_W; i++) begin
         if (i >= ld_bits) load_data[i] = ld_sign;
      end
   end

   always_comb begin
      wb_valid_d     = retire;
      wb_reg_write_d = 1'b0;
      wb_write_reg_d = wb_write_reg_q;
      wb_data_d      = wb_data_q;
      exc_d          = exc_q;
      if (retire) begin
         wb_write_reg_d = m_reg_q;
         if (m_exc_q != 2'b00) begin
            exc_d = m_exc_q;
         end else if (access && dmem_status == 2'b11) begin
            exc_d = 2'b10;
         end else begin
            exc_d = 2'b00;
         end
         wb_data_d      = (access && m_read_q && exc_d == 2'b00) ? load_data : m_alu_q;
         wb_reg_write_d = m_reg_write_q && !m_write_q && (exc_d == 2'b00);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= StIdle;
         m_valid_q      <= 1'b0;
         m_reg_write_q  <= 1'b0;
         m_read_q       <= 1'b0;
         m_write_q      <= 1'b0;
         m_size_q       <= 2'b00;
         m_unsigned_q   <= 1'b0;
         m_alu_q        <= '0;
         m_wdata_q      <= '0;
         m_reg_q        <= '0;
         m_exc_q        <= 2'b00;
         wb_valid_q     <= 1'b0;
         wb_reg_write_q <= 1'b0;
         wb_write_reg_q <= '0;
         wb_data_q      <= '0;
         exc_q          <= 2'b00;
      end else begin
         state_q        <= state_d;
         m_valid_q      <= m_valid_d;
         m_reg_write_q  <= m_reg_write_d;
         m_read_q       <= m_read_d;
         m_write_q      <= m_write_d;
         m_size_q       <= m_size_d;
         m_unsigned_q   <= m_unsigned_d;
         m_alu_q        <= m_alu_d;
         m_wdata_q      <= m_wdata_d;
         m_reg_q        <= m_reg_d;
         m_exc_q        <= m_exc_d;
         wb_valid_q     <= wb_valid_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_write_reg_q <= wb_write_reg_d;
         wb_data_q      <= wb_data_d;
         exc_q          <= exc_d;
      end
   end

   assign wb_valid_m     = wb_valid_q;
   assign wb_reg_write_m = wb_reg_write_q;
   assign wb_write_reg_m = wb_write_reg_q;
   assign wb_data_m      = wb_data_q;
   assign exc_m          = exc_q;

endmodule

// File: tb/tb_mem_stage_pipe.sv
// Directed self-checking bench for mem_stage_pipe (DATA_W=32); the misalignment scenario
// follows whether MEM_STAGE_MISALIGN_TRAP_EN is defined.
module tb_mem_stage_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_e, reg_write_e, mem_read_e, mem_write_e, unsigned_e;
   logic [1:0]  size_e;
   logic [31:0] alu_out_e, write_data_e;
   logic [4:0]  write_reg_e;
   logic        stall_m, dmem_valid, dmem_write;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic [1:0]  dmem_status;
   logic        wb_valid_m, wb_reg_write_m;
   logic [4:0]  wb_write_reg_m;
   logic [31:0] wb_data_m;
   logic [1:0]  exc_m;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage_pipe #(.DATA_W(32), .ADDR_W(32), .REG_ADDR_W(5)) dut (
      .clk(clk), .rst(rst), .valid_e(valid_e), .reg_write_e(reg_write_e),
      .mem_read_e(mem_read_e), .mem_write_e(mem_write_e), .size_e(size_e),
      .unsigned_e(unsigned_e), .alu_out_e(alu_out_e), .write_data_e(write_data_e),
      .write_reg_e(write_reg_e), .stall_m(stall_m), .dmem_valid(dmem_valid),
      .dmem_write(dmem_write), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_status(dmem_status),
      .wb_valid_m(wb_valid_m), .wb_reg_write_m(wb_reg_write_m),
      .wb_write_reg_m(wb_write_reg_m), .wb_data_m(wb_data_m), .exc_m(exc_m)
   );

   task automatic set_op(input logic v, input logic rw, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic u, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [4:0] r);
      valid_e = v; reg_write_e = rw; mem_read_e = rd; mem_write_e = wr;
      size_e = sz; unsigned_e = u; alu_out_e = alu; write_data_e = wd; write_reg_e = r;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      set_op(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h1000, 32'h0, 5'd3);
      dmem_rdata = 32'hDEADBEEF;
      dmem_status = 2'b10;
      repeat (2) @(negedge clk);
      checks++;
      if ({dmem_valid, dmem_write, stall_m, wb_valid_m, wb_reg_write_m, exc_m, dmem_be} !== 11'd0)
         begin errors++; $display("FAIL reset_ctrl: got %b, expected 0",
            {dmem_valid, dmem_write, stall_m, wb_valid_m, wb_reg_write_m, exc_m, dmem_be}); end
      checks++;
      if ({dmem_addr, dmem_wdata, wb_data_m} !== 96'd0)
         begin errors++; $display("FAIL reset_data: got %h, expected 0",
            {dmem_addr, dmem_wdata, wb_data_m}); end
      checks++;
      if (wb_write_reg_m !== 5'd0)
         begin errors++; $display("FAIL reset_reg: got %h, expected 0", wb_write_reg_m); end
      rst = 1'b1;
      valid_e = 1'b0;
      dmem_status = 2'b00;
      @(negedge clk);
   endtask

   task automatic test_load_byte();
      set_op(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 32'h1003, 32'h0, 5'd4);
      dmem_rdata = 32'h80AABBCC;
      dmem_status = 2'b10;
      @(negedge clk);
      checks++;
      if (dmem_valid !== 1'b1 || dmem_write !== 1'b0 || stall_m !== 1'b0)
         begin errors++; $display("FAIL lb_req: got v=%b w=%b s=%b, expected 1 0 0",
            dmem_valid, dmem_write, stall_m); end
      checks++;
      if (dmem_be !== 4'b1000)
         begin errors++; $display("FAIL lb_be: got %b, expected 1000", dmem_be); end
      checks++;
      if (dmem_addr !== 32'h1000)
         begin errors++; $display("FAIL lb_addr: got %h, expected 00001000", dmem_addr); end
      valid_e = 1'b0;
      @(negedge clk);
      checks++;
      if (wb_valid_m !== 1'b1 || wb_reg_write_m !== 1'b1 || exc_m !== 2'b00 ||
          wb_write_reg_m !== 5'd4)
         begin errors++; $display("FAIL lb_wb_ctrl: got v=%b rw=%b exc=%b reg=%0d, expected 1 1 00 4",
            wb_valid_m, wb_reg_write_m, exc_m, wb_write_reg_m); end
      checks++;
      if (wb_data_m !== 32'hFFFFFF80)
         begin errors++; $display("FAIL lb_data: got %h, expected ffffff80", wb_data_m); end
      dmem_status = 2'b00;
   endtask

   task automatic test_store_half_busy();
      int stall_cnt = 0;
      int pulses = 0;
      set_op(1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b0, 32'h2002, 32'h1234, 5'd9);
      dmem_status = 2'b01;
      @(negedge clk);
      checks++;
      if (dmem_be !== 4'b1100 || dmem_write !== 1'b1 || dmem_addr !== 32'h2000)
         begin errors++; $display("FAIL sh_req: got be=%b w=%b addr=%h, expected 1100 1 00002000",
            dmem_be, dmem_write, dmem_addr); end
      checks++;
      if (dmem_wdata !== 32'h12341234)
         begin errors++; $display("FAIL sh_wdata: got %h, expected 12341234", dmem_wdata); end
      repeat (3) begin
         if (stall_m === 1'b1) stall_cnt++;
         if (wb_valid_m === 1'b1) pulses++;
         @(negedge clk);
      end
      dmem_status = 2'b10;
      valid_e = 1'b0;
      #1;
      checks++;
      if (stall_m !== 1'b0 || dmem_valid !== 1'b1)
         begin errors++; $display("FAIL sh_done: got stall=%b v=%b, expected 0 1", stall_m, dmem_valid); end
      @(negedge clk);
      if (wb_valid_m === 1'b1) pulses++;
      checks++;
      if (wb_valid_m !== 1'b1 || wb_reg_write_m !== 1'b0 || exc_m !== 2'b00)
         begin errors++; $display("FAIL sh_wb: got v=%b rw=%b exc=%b, expected 1 0 00",
            wb_valid_m, wb_reg_write_m, exc_m); end
      @(negedge clk);
      if (wb_valid_m === 1'b1) pulses++;
      checks++;
      if (stall_cnt !== 3)
         begin errors++; $display("FAIL sh_stall_cycles: got %0d, expected 3", stall_cnt); end
      checks++;
      if (pulses !== 1)
         begin errors++; $display("FAIL sh_pulses: got %0d, expected 1", pulses); end
      dmem_status = 2'b00;
   endtask

   task automatic test_bus_error();
      set_op(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h3000, 32'h0, 5'd6);
      dmem_status = 2'b11;
      @(negedge clk);
      set_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0000ABCD, 32'h0, 5'd7);
      @(negedge clk);
      checks++;
      if (wb_valid_m !== 1'b1 || exc_m !== 2'b10 || wb_reg_write_m !== 1'b0)
         begin errors++; $display("FAIL be_wb: got v=%b exc=%b rw=%b, expected 1 10 0",
            wb_valid_m, exc_m, wb_reg_write_m); end
      checks++;
      if (wb_data_m !== 32'h3000)
         begin errors++; $display("FAIL be_addr: got %h, expected 00003000", wb_data_m); end
      valid_e = 1'b0;
      @(negedge clk);
      checks++;
      if (wb_valid_m !== 1'b1 || wb_data_m !== 32'h0000ABCD || exc_m !== 2'b00 ||
          wb_reg_write_m !== 1'b1 || wb_write_reg_m !== 5'd7)
         begin errors++; $display("FAIL be_next: got v=%b d=%h exc=%b rw=%b reg=%0d, expected 1 0000abcd 00 1 7",
            wb_valid_m, wb_data_m, exc_m, wb_reg_write_m, wb_write_reg_m); end
      dmem_status = 2'b00;
   endtask

   task automatic test_misalign();
      set_op(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h4001, 32'h0, 5'd8);
      dmem_rdata = 32'h11223344;
      dmem_status = 2'b10;
      @(negedge clk);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
      checks++;
      if (dmem_valid !== 1'b0)
         begin errors++; $display("FAIL mis_noreq: got %b, expected 0", dmem_valid); end
      valid_e = 1'b0;
      @(negedge clk);
      checks++;
      if (wb_valid_m !== 1'b1 || exc_m !== 2'b01 || wb_reg_write_m !== 1'b0 ||
          wb_data_m !== 32'h4001)
         begin errors++; $display("FAIL mis_wb: got v=%b exc=%b rw=%b d=%h, expected 1 01 0 00004001",
            wb_valid_m, exc_m, wb_reg_write_m, wb_data_m); end
      checks++;
      if (dmem_valid !== 1'b0)
         begin errors++; $display("FAIL mis_noreq2: got %b, expected 0", dmem_valid); end
`else
      checks++;
      if (dmem_valid !== 1'b1 || dmem_addr !== 32'h4000 || dmem_be !== 4'hF)
         begin errors++; $display("FAIL mis_req: got v=%b addr=%h be=%b, expected 1 00004000 1111",
            dmem_valid, dmem_addr, dmem_be); end
      valid_e = 1'b0;
      @(negedge clk);
      checks++;
      if (wb_valid_m !== 1'b1 || exc_m !== 2'b00 || wb_reg_write_m !== 1'b1 ||
          wb_data_m !== 32'h11223344)
         begin errors++; $display("FAIL mis_wb: got v=%b exc=%b rw=%b d=%h, expected 1 00 1 11223344",
            wb_valid_m, exc_m, wb_reg_write_m, wb_data_m); end
`endif
      dmem_status = 2'b00;
   endtask

   task automatic test_reset_mid_access();
      int pulses = 0;
      set_op(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b1, 32'h5000, 32'h0, 5'd10);
      dmem_status = 2'b01;
      @(negedge clk);
      @(negedge clk);
      checks++;
      if (stall_m !== 1'b1 || dmem_valid !== 1'b1)
         begin errors++; $display("FAIL rma_busy: got stall=%b v=%b, expected 1 1", stall_m, dmem_valid); end
      rst = 1'b0;
      valid_e = 1'b0;
      @(negedge clk);
      checks++;
      if (dmem_valid !== 1'b0 || stall_m !== 1'b0)
         begin errors++; $display("FAIL rma_drop: got v=%b stall=%b, expected 0 0", dmem_valid, stall_m); end
      rst = 1'b1;
      dmem_status = 2'b10;
      repeat (3) begin
         @(negedge clk);
         if (wb_valid_m !== 1'b0) pulses++;
      end
      checks++;
      if (pulses !== 0)
         begin errors++; $display("FAIL rma_noretire: got %0d pulses, expected 0", pulses); end
      dmem_status = 2'b00;
   endtask

   task automatic test_back_to_back();
      set_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h00000011, 32'h0, 5'd1);
      @(negedge clk);
      set_op(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h00000022, 32'h0, 5'd2);
      @(negedge clk);
      checks++;
      if (wb_valid_m !== 1'b1 || wb_data_m !== 32'h11 || wb_reg_write_m !== 1'b1 ||
          wb_write_reg_m !== 5'd1)
         begin errors++; $display("FAIL b2b_a: got v=%b d=%h rw=%b reg=%0d, expected 1 00000011 1 1",
            wb_valid_m, wb_data_m, wb_reg_write_m, wb_write_reg_m); end
      valid_e = 1'b0;
      @(negedge clk);
      checks++;
      if (wb_valid_m !== 1'b1 || wb_data_m !== 32'h22 || wb_reg_write_m !== 1'b0 ||
          wb_write_reg_m !== 5'd2)
         begin errors++; $display("FAIL b2b_b: got v=%b d=%h rw=%b reg=%0d, expected 1 00000022 0 2",
            wb_valid_m, wb_data_m, wb_reg_write_m, wb_write_reg_m); end
      set_op(1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h00000033, 32'h0, 5'd3);
      @(negedge clk);
      checks++;
      if (wb_valid_m !== 1'b0)
         begin errors++; $display("FAIL b2b_bubble: got %b, expected 0", wb_valid_m); end
      valid_e = 1'b0;
      @(negedge clk);
      checks++;
      if (wb_valid_m !== 1'b1 || wb_data_m !== 32'h33 || wb_write_reg_m !== 5'd3)
         begin errors++; $display("FAIL b2b_c: got v=%b d=%h reg=%0d, expected 1 00000033 3",
            wb_valid_m, wb_data_m, wb_write_reg_m); end
   endtask

   initial begin
      rst = 1'b0;
      set_op(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0, 5'd0);
      dmem_rdata = 32'h0;
      dmem_status = 2'b00;
      @(negedge clk);
      test_reset();
      test_load_byte();
      test_store_half_busy();
      test_bus_error();
      test_misalign();
      test_reset_mid_access();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
